// File: rtl/joystick_snapshot.sv
// joystick_snapshot
//   Frame-coherent capture of the multi-player joystick bus. Each vblank rising
//   edge (seen while idle) latches the raw bus. The latched words are then
//   scanned one player per cycle into the published snapshot, together with
//   per-bit press/release edges and per-player activity/change flags. One
//   update pulse marks the end of each scan.
//
//   Optional feature macro: JOYSTICK_SNAPSHOT_DEBOUNCE_EN
//     When defined, a bit is published only after it reads the same level on
//     two consecutive scans. Until then the previously published bit is kept.
//
// Ports
//   clk_sys         in   system clock, rising edge
//   reset           in   synchronous, active-high
//   joystick_raw    in   live bus, player p at [32p +: 32]
//   vblank          in   active-high vertical blank
//   joystick        out  committed snapshot
//   pressed         out  bits that went 0->1 at the player's latest scan
//   released        out  bits that went 1->0 at the player's latest scan
//   player_active   out  player snapshot word nonzero
//   player_changed  out  player snapshot word differs from its previous value
//   frame_count     out  completed scans, wraps silently
//   update          out  one-cycle pulse after a scan completes
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a vblank rising edge
// CAPTURE  | latch joystick_raw into raw_buf, reset player index
// SCAN     | publish player pidx, one player per cycle
// COMMIT   | bump frame counter, raise update for the following cycle

module joystick_snapshot #(
  parameter int PLAYERS = 6,
  parameter int FCNT_W  = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [32*PLAYERS-1:0]   joystick_raw,
  input  logic                    vblank,
  output logic [32*PLAYERS-1:0]   joystick,
  output logic [32*PLAYERS-1:0]   pressed,
  output logic [32*PLAYERS-1:0]   released,
  output logic [PLAYERS-1:0]      player_active,
  output logic [PLAYERS-1:0]      player_changed,
  output logic [FCNT_W-1:0]       frame_count,
  output logic                    update
);

  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(PLAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SCAN    = 3'd2,
    S_COMMIT  = 3'd3
  } state_t;

  state_t state, state_nxt;

  logic              vblank_q;
  logic [PW-1:0]     pidx;
  logic [31:0]       raw_buf  [PLAYERS];
  logic [31:0]       snap_q   [PLAYERS];
  logic [31:0]       press_q  [PLAYERS];
  logic [31:0]       rel_q    [PLAYERS];
  logic [PLAYERS-1:0] active_q;
  logic [PLAYERS-1:0] changed_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              update_q;

`ifdef JOYSTICK_SNAPSHOT_DEBOUNCE_EN
  logic [31:0]       prev_raw [PLAYERS];
  logic [31:0]       stable_w;
`endif

  logic [31:0] old_w;
  logic [31:0] raw_w;
  logic [31:0] new_w;
  logic        vb_rise;
  logic        scan_last;

  assign vb_rise   = vblank && !vblank_q;
  assign scan_last = (pidx == LAST_P);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    old_w     = snap_q[pidx];
    raw_w     = raw_buf[pidx];
`ifdef JOYSTICK_SNAPSHOT_DEBOUNCE_EN
    // Bits that disagree with the previous scan hold their published value.
    stable_w  = ~(raw_w ^ prev_raw[pidx]);
    new_w     = (raw_w & stable_w) | (old_w & ~stable_w);
`else
    new_w     = raw_w;
`endif
    case (state)
      S_IDLE:    if (vb_rise) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_SCAN;
      S_SCAN:    if (scan_last) state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // vblank_q starts high so a vblank already asserted at reset release
      // does not look like a fresh rising edge.
      vblank_q  <= 1'b1;
      pidx      <= '0;
      update_q  <= 1'b0;
      fcnt_q    <= '0;
      active_q  <= '0;
      changed_q <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        raw_buf[p] <= '0;
        snap_q[p]  <= '0;
        press_q[p] <= '0;
        rel_q[p]   <= '0;
`ifdef JOYSTICK_SNAPSHOT_DEBOUNCE_EN
        prev_raw[p] <= '0;
`endif
      end
    end else begin
      vblank_q <= vblank;
      update_q <= (state == S_COMMIT);
      case (state)
        S_CAPTURE: begin
          for (int p = 0; p < PLAYERS; p++)
            raw_buf[p] <= joystick_raw[32*p +: 32];
          pidx <= '0;
        end
        S_SCAN: begin
          snap_q[pidx]    <= new_w;
          press_q[pidx]   <= new_w & ~old_w;
          rel_q[pidx]     <= old_w & ~new_w;
          changed_q[pidx] <= (new_w != old_w);
          active_q[pidx]  <= (new_w != 32'd0);
`ifdef JOYSTICK_SNAPSHOT_DEBOUNCE_EN
          prev_raw[pidx]  <= raw_w;
`endif
          if (!scan_last) pidx <= pidx + PW'(1);
        end
        S_COMMIT: fcnt_q <= fcnt_q + FCNT_W'(1);
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < PLAYERS; g++) begin : g_out
    assign joystick[32*g +: 32] = snap_q[g];
    assign pressed[32*g +: 32]  = press_q[g];
    assign released[32*g +: 32] = rel_q[g];
  end

  assign player_active  = active_q;
  assign player_changed = changed_q;
  assign frame_count    = fcnt_q;
  assign update         = update_q;

endmodule
